// File: rtl/univ_shift_register.sv
// univ_shift_register: parametrised universal shift register with burst FSM; UNIV_SREG_PARITY_EN adds a registered parity output
module univ_shift_register #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int AMT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             din,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             sout_valid
`ifdef UNIV_SREG_PARITY_EN
  ,
  output logic             parity
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [AMT_W-1:0] WMAX = AMT_W'(WIDTH);
  state_t state, state_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt, amt_c;
  logic dir_l, dir_nxt, sh_dir, sh_req, sh_do, sh_out, fill_l, fill_r;
  logic [1:0] mode_l, mode_nxt, sh_mode;
  logic [WIDTH-1:0] q_sh, q_nxt;
  assign amt_c = (amount > WMAX) ? WMAX : amount;
  // RUN shifts with the latched controls; IDLE/DONE single-step with the live ones
  assign sh_req = !load && (state == RUN || (!start && en));
  assign sh_dir = (state == RUN) ? dir_l : dir;
  assign sh_mode = (state == RUN) ? mode_l : mode;
  assign sh_do = sh_req && sh_mode != 2'b11;
  assign sh_out = sh_dir ? q[0] : q[WIDTH-1];
  always_comb begin
    fill_l = (sh_mode == 2'b01) ? q[WIDTH-1] : din;
    fill_r = (sh_mode == 2'b01) ? q[0] : (sh_mode == 2'b10) ? q[WIDTH-1] : din;
    q_sh = sh_dir ? {fill_r, q[WIDTH-1:1]} : {q[WIDTH-2:0], fill_l};
    q_nxt = load ? d : sh_do ? q_sh : q;
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    dir_nxt = dir_l;
    mode_nxt = mode_l;
    if (load) state_nxt = IDLE;
    else if (state == RUN) begin
      cnt_nxt = cnt - 1'b1;
      state_nxt = (cnt == AMT_W'(1)) ? DONE : RUN;
    end else if (start) begin
      state_nxt = (amt_c == '0) ? DONE : RUN;
      cnt_nxt = amt_c;
      dir_nxt = dir;
      mode_nxt = mode;
    end else state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      dir_l <= 1'b0;
      mode_l <= 2'b00;
      q <= RESET_VAL;
      sout <= 1'b0;
      sout_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      dir_l <= dir_nxt;
      mode_l <= mode_nxt;
      q <= q_nxt;
      if (sh_do) sout <= sh_out;
      sout_valid <= sh_do;
      busy <= state_nxt == RUN;
      done <= state_nxt == DONE;
    end
`ifdef UNIV_SREG_PARITY_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) parity <= ^RESET_VAL;
    else parity <= ^q_nxt;
`endif
endmodule

// File: tb/tb_univ_shift_register.sv
// tb_univ_shift_register: directed plan steps plus random traffic against a behavioural model
module tb_univ_shift_register;
  logic clk = 1'b0;
  logic rst, load, en, dir, din, start;
  logic [7:0] d;
  logic [1:0] mode;
  logic [3:0] amount;
  logic busy, done, sout, sout_valid;
  logic [7:0] q;
`ifdef UNIV_SREG_PARITY_EN
  logic parity;
`endif
  int n_assert = 0;
  int n_fail = 0;
  logic [7:0] m_q;
  int m_rem;
  bit m_done, m_sv, m_sout, m_dir;
  logic [1:0] m_mode;
  int bcnt;

  univ_shift_register #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .load(load), .d(d), .en(en), .dir(dir), .mode(mode),
    .din(din), .start(start), .amount(amount), .busy(busy), .done(done), .q(q),
    .sout(sout), .sout_valid(sout_valid)
`ifdef UNIV_SREG_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_q = 8'h00; m_rem = 0; m_done = 0; m_sv = 0; m_sout = 0; m_dir = 0; m_mode = 2'b00;
  endtask

  task automatic mstep();
    bit sh, sd;
    logic [1:0] sm;
    logic [7:0] nq;
    int k;
    sh = 0; sd = 0; sm = 2'b00; m_sv = 0;
    if (load) begin
      m_q = d; m_rem = 0; m_done = 0;
    end else if (m_rem > 0) begin
      sd = m_dir; sm = m_mode; sh = 1; m_rem--; m_done = (m_rem == 0);
    end else begin
      m_done = 0;
      if (start) begin
        k = (amount > 8) ? 8 : int'(amount);
        m_rem = k; m_dir = dir; m_mode = mode; m_done = (k == 0);
      end else if (en) begin
        sd = dir; sm = mode; sh = 1;
      end
    end
    if (sh && sm != 2'b11) begin
      if (!sd) nq = (m_q << 1) | ((sm == 2'b01) ? (m_q >> 7) : {7'b0, din});
      else if (sm == 2'b01) nq = (m_q >> 1) | (m_q << 7);
      else if (sm == 2'b10) nq = 8'($signed(m_q) >>> 1);
      else nq = (m_q >> 1) | {din, 7'b0};
      m_sout = sd ? m_q[0] : m_q[7];
      m_q = nq;
      m_sv = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) mreset(); else mstep();
    #1;
    chk("model_q", q, m_q);
    chk("model_busy", busy, m_rem > 0);
    chk("model_done", done, m_done);
    chk("model_sout_valid", sout_valid, m_sv);
    chk("model_sout", sout, m_sout);
`ifdef UNIV_SREG_PARITY_EN
    chk("model_parity", parity, ^m_q);
`endif
  endtask

  task automatic run_burst(input bit spurious, output int bc);
    bc = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) bc++;
      if (done) break;
      if (spurious) begin start = 1; en = 1; end
      tick();
    end
    start = 0; en = 0;
    chk("burst_done_seen", done, 1);
  endtask

  initial begin
    rst = 1; load = 0; en = 0; dir = 0; din = 0; start = 0; d = 8'h00; mode = 2'b00; amount = 4'd0;
    mreset();
    #1;
    chk("reset_q", q, 8'h00);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sv", sout_valid, 0);
    tick(); tick();
    rst = 0;
    load = 1; d = 8'hA5;
    tick();
    load = 0;
    chk("load_q", q, 8'hA5);
    chk("load_busy", busy, 0);
    chk("load_sv", sout_valid, 0);
    load = 1; d = 8'h81;
    tick();
    load = 0; en = 1; dir = 0; mode = 2'b00; din = 1;
    tick();
    chk("step1_q", q, 8'h03);
    chk("step1_sout", sout, 1);
    chk("step1_sv", sout_valid, 1);
    tick();
    en = 0;
    chk("step2_q", q, 8'h07);
    chk("step2_sout", sout, 0);
    chk("step2_sv", sout_valid, 1);
`ifdef UNIV_SREG_PARITY_EN
    chk("parity_07", parity, 1);
`endif
    tick();
    chk("step_idle_sv", sout_valid, 0);
    load = 1; d = 8'hA5;
    tick();
    load = 0; amount = 4'd3; dir = 1; mode = 2'b01;
    run_burst(1, bcnt);
    chk("rot3_busy_cycles", bcnt, 3);
    chk("rot3_q", q, 8'hB4);
    tick();
    chk("rot3_done_pulse", done, 0);
    amount = 4'd8;
    run_burst(0, bcnt);
    chk("rot8_busy_cycles", bcnt, 8);
    chk("rot8_q", q, 8'hB4);
    tick();
    load = 1; d = 8'h90;
    tick();
    load = 0; amount = 4'd9; dir = 1; mode = 2'b10;
    run_burst(0, bcnt);
    chk("asr9_busy_cycles", bcnt, 8);
    chk("asr9_q", q, 8'hFF);
    tick();
    amount = 4'd0;
    run_burst(0, bcnt);
    chk("amt0_busy_cycles", bcnt, 0);
    chk("amt0_q", q, 8'hFF);
    tick();
    chk("amt0_done_pulse", done, 0);
    amount = 4'd5; dir = 0; mode = 2'b01;
    start = 1;
    tick();
    start = 0;
    tick();
    chk("abort_run2_busy", busy, 1);
    load = 1; d = 8'h3C;
    tick();
    load = 0;
    chk("abort_q", q, 8'h3C);
    chk("abort_busy", busy, 0);
    chk("abort_no_done", done, 0);
    tick();
    chk("abort_no_done_late", done, 0);
    amount = 4'd6;
    start = 1;
    tick();
    start = 0;
    tick();
    #2 rst = 1;
    #1;
    mreset();
    chk("arst_q", q, 8'h00);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sv", sout_valid, 0);
    tick(); tick();
    rst = 0;
    tick();
    chk("arst_after_done", done, 0);
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 19) == 0);
      start = ($urandom_range(0, 7) == 0);
      en = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
      din = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      amount = 4'($urandom_range(0, 15));
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
